channel_tx_arbiter: RTL and testbench
=====================================

# channel_tx_arbiter

Shares the single 8-bit command byte stream to the host link between four channel sources: the target-machine selector on channel 3 and three other channels. Each source's word is sent only when its value changes. Pending sources are served round-robin, the channel field is stamped on each word, and each byte is handed to the byte transmitter over a valid/ready handshake. A minimum inter-byte gap is enforced between transfers.

## Interface
Parameters:
- `GAP_CYCLES`, default 16: idle cycles enforced after each accepted byte; 0 is legal.
- `IGNORE_CODE`, default 8'b000000_11: a source word equal to this is never sent.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `src_data`, in, 32: source i word at bits [8i+7:8i]; bit 7 = 0, bits [6:2] = value field, bits [1:0] ignored.
- `src_en`, in, 4: source i participates only while `src_en[i]` = 1.
- `tx_data`, out, 8: byte offered to the transmitter.
- `tx_valid`, out, 1: `tx_data` valid.
- `tx_ready`, in, 1: transmitter accepts when `tx_valid` && `tx_ready` at a rising edge.
- `grant`, out, 2: index of the source currently offered, or last offered.
- `busy`, out, 1: state ≠ IDLE.

Reset values: `tx_data` = 0, `tx_valid` = 0, `grant` = 2'd3, `busy` = 0.

## Operation
- **Per-source registers:** `last_val[i]` (bits [7:2], reset 0) and `sent[i]` (reset 0).
- **Pending (combinational):**
  - `pend[i]` = `src_en[i]` && `src_data[i]` ≠ `IGNORE_CODE` && (!`sent[i]` || `src_data[i][7:2]` ≠ `last_val[i]`).
  - A source that returns to its last-sent value before being granted is no longer pending.
- **Round-robin pointer:** `ptr` (reset 3). Search order is `ptr`+1, `ptr`+2, `ptr`+3, `ptr` (mod 4), so source 0 wins first after reset.
- **FSM states:** IDLE, SEND, GAP.
  - **IDLE:** if any `pend`:
    - pick winner g;
    - register `tx_data` = {`src_data[g][7:2]`, g[1:0]};
    - `grant` = g, `tx_valid` = 1;
    - go to SEND.
  - **SEND:** `tx_data`, `grant` and `tx_valid` are held stable until handshake. Source changes, `src_en` drop or new pending requests do not alter the offered byte. On handshake:
    - `last_val[g]` = `tx_data[7:2]`, `sent[g]` = 1, `ptr` = g;
    - `tx_valid` = 0;
    - load `gap_cnt` = `GAP_CYCLES`;
    - go to GAP, or to IDLE if `GAP_CYCLES` = 0.
  - **GAP:** decrement `gap_cnt`; when `gap_cnt` = 1 go to IDLE.
- **Source changes mid-SEND:** if the granted source changes during SEND, the latched value is what gets recorded as sent, so the new value becomes pending again after the gap.
- **Reset mid-operation:** everything returns to reset values immediately, and all `sent` flags clear, so every enabled source is re-sent after reset.
- **Counter width:** `gap_cnt` is wide enough for `GAP_CYCLES`; no wrap-around.

## Timing
- `tx_valid` rises one cycle after the IDLE cycle in which `pend` is nonzero (registered output).
- After handshake at edge T:
  - `tx_valid` is low from T.
  - The earliest next `tx_valid` is at edge T + `GAP_CYCLES` + 1.
  - With `GAP_CYCLES` = 0, the earliest next `tx_valid` is at edge T + 1.
- No combinational path from `tx_ready` to `tx_valid` or `tx_data`.
- A pending request with no competition is offered within 1 cycle of IDLE.
- With all four sources pending, each is served at most once per four grants.

## Structure
- **Shared package:**
  - `IGNORE_CODE`;
  - channel constants: `CHANNEL_TARGET` = 2'b11, other channels 2'b00 to 2'b10;
  - FSM state encoding;
  - `SELECT_VALUE_MAX` (20), used by the sources, not here.
- **One sub-module:** `rr_pick4`, a combinational 4-way round-robin picker (inputs `pend[3:0]`, `ptr[1:0]`; outputs `any`, `win[1:0]`).
- The rest is one FSM plus per-source registers.

## Test plan
- **Reset, single source:** reset, then `src_en` = 4'b1000 with `src_data[31:24]` = 8'h2B. Expect `tx_data` = 8'h2B, `grant` = 3, `tx_valid` 1 cycle after release. Hold `tx_ready` = 1. Expect exactly one byte; a constant input sends nothing more.
- **Change and ignore:** source 3 goes 8'h2B → 8'h2F. Expect 8'h2F after `GAP_CYCLES` + 1. Then source 3 = 8'h03 (`IGNORE_CODE`). Expect no transfer.
- **Round-robin:** all four enabled and pending, with values 8'h04, 8'h08, 8'h0C, 8'h10. Expect the order 0, 1, 2, 3: bytes 8'h04, 8'h09, 8'h0E, 8'h13 (channel stamped). Each byte is separated by ≥ `GAP_CYCLES` + 1 cycles.
- **Backpressure:** hold `tx_ready` = 0 for 50 cycles while source 0 changes 8'h04 → 8'h14. Expect `tx_data` stuck at 8'h04. After acceptance and the gap, 8'h14 is sent.
- **Reset mid-SEND:** assert `rst_n` = 0 while `tx_valid` = 1. Expect `tx_valid` = 0 asynchronously. After release the same unchanged source value is re-sent.
- **Zero gap:** `GAP_CYCLES` = 0 with two sources pending and `tx_ready` = 1. Expect valid bytes on consecutive handshakes with a one-cycle IDLE between them.

Source files
------------

// File: rtl/channel_tx_arbiter_pkg.sv
// Shared constants and types for the host-link channel transmit arbiter
// and the channel sources feeding it.
package channel_tx_arbiter_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam logic [7:0] IGNORE_CODE = 8'b000000_11;

  localparam logic [1:0] CHANNEL_0      = 2'b00;
  localparam logic [1:0] CHANNEL_1      = 2'b01;
  localparam logic [1:0] CHANNEL_2      = 2'b10;
  localparam logic [1:0] CHANNEL_TARGET = 2'b11;

  // Largest target-machine select value the sources may present.
  localparam int unsigned SELECT_VALUE_MAX = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker; search starts just after ptr
// and wraps, so ptr itself has the lowest priority.
module rr_pick4 (
  input  logic [3:0] pend,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] win
);

  // Walk from farthest to nearest so the nearest pending source wins.
  always_comb begin
    any = 1'b0;
    win = ptr;
    for (int k = 4; k >= 1; k--) begin
      if (pend[ptr + 2'(k)]) begin
        any = 1'b1;
        win = ptr + 2'(k);
      end
    end
  end

endmodule

// File: rtl/channel_tx_arbiter.sv
// Change-driven, round-robin arbiter sharing one command byte stream between
// four channel sources, with a fixed idle gap after every accepted byte.
module channel_tx_arbiter #(
  parameter int unsigned GAP_CYCLES  = 16,
  parameter logic [7:0]  IGNORE_CODE = channel_tx_arbiter_pkg::IGNORE_CODE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] src_data,
  input  logic [3:0]  src_en,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [1:0]  grant,
  output logic        busy
);
  import channel_tx_arbiter_pkg::*;

  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  logic [NUM_SRC-1:0][7:0] src_w;
  logic [NUM_SRC-1:0][5:0] last_val;
  logic [NUM_SRC-1:0]      sent;
  logic [NUM_SRC-1:0]      pend;
  logic [1:0]              ptr;
  logic [1:0]              win;
  logic                    any;
  logic                    hs;
  logic [GW-1:0]           gap_cnt;
  state_t                  state, state_d;

  assign src_w = src_data;
  assign hs    = tx_valid && tx_ready;
  assign busy  = (state != ST_IDLE);

  // A source is pending only while its value differs from what was last sent.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_pend
    assign pend[i] = src_en[i] && (src_w[i] != IGNORE_CODE) &&
                     (!sent[i] || (src_w[i][7:2] != last_val[i]));
  end

  rr_pick4 u_pick (
    .pend (pend),
    .ptr  (ptr),
    .any  (any),
    .win  (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: if (any) state_d = ST_SEND;
      ST_SEND: if (hs)  state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:  if (gap_cnt == GW'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The offered byte is latched at grant time and is what gets recorded as
  // sent, so a source that moves during SEND is picked up again later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      grant    <= 2'd3;
      ptr      <= 2'd3;
      gap_cnt  <= '0;
      last_val <= '0;
      sent     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (any) begin
          tx_data  <= {src_w[win][7:2], win};
          grant    <= win;
          tx_valid <= 1'b1;
        end
        ST_SEND: if (hs) begin
          last_val[grant] <= tx_data[7:2];
          sent[grant]     <= 1'b1;
          ptr             <= grant;
          tx_valid        <= 1'b0;
          gap_cnt         <= GW'(GAP_CYCLES);
        end
        ST_GAP:  gap_cnt <= gap_cnt - GW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_tx_arbiter.sv
// Self-checking bench: table-driven source patterns plus hand-written
// reset/backpressure/zero-gap sequences, checked through byte scoreboards.
module tb_channel_tx_arbiter;

  localparam int GAP = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] src_data_a, src_data_b;
  logic [3:0]  src_en_a, src_en_b;
  logic        tx_ready_a, tx_ready_b;
  logic [7:0]  tx_data_a, tx_data_b;
  logic        tx_valid_a, tx_valid_b;
  logic [1:0]  grant_a, grant_b;
  logic        busy_a, busy_b;

  always #5 clk = ~clk;

  channel_tx_arbiter #(.GAP_CYCLES(GAP)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .src_data(src_data_a), .src_en(src_en_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .grant(grant_a), .busy(busy_a)
  );

  channel_tx_arbiter #(.GAP_CYCLES(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .src_data(src_data_b), .src_en(src_en_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .grant(grant_b), .busy(busy_b)
  );

  typedef struct {
    logic [3:0]       en;
    logic [31:0]      data;
    int               n;
    logic [3:0][7:0]  exp;
  } vec_t;

  vec_t       tbl[4];
  int         checks = 0, failures = 0, cyc = 0;
  logic [7:0] q_a[$], q_b[$];
  int         hs_a = 0, hs_b = 0, last_hs_a = 0, last_hs_b = 0, prev_hs_b = 0;
  bit         seen_a = 0, seen_b = 0, pv_a = 0, pv_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_gap(input string name, input int diff, input int need);
    checks++;
    if (diff < need) begin
      failures++;
      $display("FAIL %s: spacing %0d cycles, need >= %0d (cycle %0d)", name, diff, need, cyc);
    end
  endtask

  // Sampled at the falling edge: a valid&&ready seen here completes at the next rising edge.
  task automatic mon();
    logic [7:0] e;
    if (rst_n) begin
      if (tx_valid_a && !pv_a && seen_a) chk_gap("gap_a", cyc - last_hs_a, GAP + 1);
      if (tx_valid_a && tx_ready_a) begin
        if (q_a.size() == 0) chk("unexpected_a", {24'h0, tx_data_a}, 32'hFFFF_FFFF);
        else begin
          e = q_a.pop_front();
          chk("byte_a", tx_data_a, e);
          chk("grant_a", grant_a, e[1:0]);
        end
        last_hs_a = cyc + 1; seen_a = 1; hs_a++;
      end
      if (tx_valid_b && !pv_b && seen_b) chk_gap("gap_b", cyc - last_hs_b, 1);
      if (tx_valid_b && tx_ready_b) begin
        if (q_b.size() == 0) chk("unexpected_b", {24'h0, tx_data_b}, 32'hFFFF_FFFF);
        else begin
          e = q_b.pop_front();
          chk("byte_b", tx_data_b, e);
          chk("grant_b", grant_b, e[1:0]);
        end
        prev_hs_b = last_hs_b; last_hs_b = cyc + 1; seen_b = 1; hs_b++;
      end
      pv_a = tx_valid_a;
      pv_b = tx_valid_b;
    end else begin
      pv_a = 0; seen_a = 0; pv_b = 0; seen_b = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain_a(input int bound);
    int n = 0;
    while (q_a.size() != 0 && n < bound) begin tick(); n++; end
    if (q_a.size() != 0) begin
      chk("drain_a_timeout", q_a.size(), 0);
      q_a.delete();
    end
  endtask

  task automatic drain_b(input int bound);
    int n = 0;
    while (q_b.size() != 0 && n < bound) begin tick(); n++; end
    if (q_b.size() != 0) begin
      chk("drain_b_timeout", q_b.size(), 0);
      q_b.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    tbl[0] = '{4'b1000, 32'h2B00_0000, 0, 32'h0};          // unchanged: nothing new
    tbl[1] = '{4'b1000, 32'h2F00_0000, 1, 32'h0000_002F};  // changed value
    tbl[2] = '{4'b1000, 32'h0300_0000, 0, 32'h0};          // ignore code
    tbl[3] = '{4'b1111, 32'h100C_0804, 4, 32'h130E_0904};  // round robin 0..3

    src_en_a = '0; src_data_a = '0; tx_ready_a = 1'b1;
    src_en_b = '0; src_data_b = '0; tx_ready_b = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", tx_valid_a, 0);
    chk("rst_data", tx_data_a, 8'h00);
    chk("rst_grant", grant_a, 2'd3);
    chk("rst_busy", busy_a, 0);
    chk("rst_grant_b", grant_b, 2'd3);

    src_en_a = 4'b1000; src_data_a = 32'h2B00_0000;
    q_a.push_back(8'h2B);
    tick(); tick();
    chk("rst_hold_valid", tx_valid_a, 0);
    rst_n = 1'b1;
    tick();
    chk("first_valid", tx_valid_a, 1);
    chk("first_data", tx_data_a, 8'h2B);
    chk("first_grant", grant_a, 2'd3);
    chk("first_busy", busy_a, 1);
    drain_a(50);

    for (int r = 0; r < 4; r++) begin
      src_en_a = tbl[r].en;
      src_data_a = tbl[r].data;
      for (int k = 0; k < tbl[r].n; k++) q_a.push_back(tbl[r].exp[k]);
      h0 = hs_a;
      drain_a(400);
      repeat (40) tick();
      chk($sformatf("row%0d_count", r), hs_a - h0, tbl[r].n);
    end

    // Reset with all sources up, then reset again while a byte is offered.
    tx_ready_a = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rr_rst_valid", tx_valid_a, 1);
    chk("rr_rst_data", tx_data_a, 8'h04);
    chk("rr_rst_grant", grant_a, 2'd0);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", tx_valid_a, 0);
    chk("async_rst_data", tx_data_a, 8'h00);
    chk("async_rst_grant", grant_a, 2'd3);
    chk("async_rst_busy", busy_a, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("resend_valid", tx_valid_a, 1);
    chk("resend_data", tx_data_a, 8'h04);

    // Backpressure: offered byte must not follow the source.
    for (int i = 0; i < 50; i++) begin
      if (i == 10) src_data_a[7:0] = 8'h14;
      tick();
      chk("bp_hold", {21'h0, tx_valid_a, grant_a, tx_data_a}, {21'h0, 1'b1, 2'd0, 8'h04});
    end
    q_a.push_back(8'h04); q_a.push_back(8'h09); q_a.push_back(8'h0E);
    q_a.push_back(8'h13); q_a.push_back(8'h14);
    h0 = hs_a;
    tx_ready_a = 1'b1;
    drain_a(400);
    repeat (40) tick();
    chk("bp_count", hs_a - h0, 5);

    // Zero gap: back-to-back handshakes two cycles apart.
    src_en_b = 4'b0011; src_data_b = 32'h0000_0804;
    q_b.push_back(8'h04); q_b.push_back(8'h09);
    h0 = hs_b;
    drain_b(50);
    repeat (5) tick();
    chk("zero_gap_count", hs_b - h0, 2);
    chk("zero_gap_spacing", last_hs_b - prev_hs_b, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
